// File: rtl/cmip_app_cnt_bank.sv
// Bank of CH event counters with sticky overflow, snapshot shadow registers
// and a request/ack read port that returns one shadowed channel per request.
module cmip_app_cnt_bank #(
  parameter int CH          = 4,
  parameter int WIDTH       = 16,
  parameter int SAT         = 0,
  parameter int CLR_ON_SNAP = 0,
  parameter int IW          = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CH-1:0]    vld,
  input  logic             snap,
  output logic             snap_done,
  input  logic             rd_req,
  input  logic [IW-1:0]    rd_idx,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_ovf,
  output logic [CH-1:0]    ovf
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_WAIT = 2'd2
  } rd_state_t;

  logic [WIDTH-1:0] cnt_r     [CH];
  logic [WIDTH-1:0] cnt_nxt_s [CH];
  logic [CH-1:0]    ovf_r;
  logic [CH-1:0]    ovf_nxt_s;
  logic [WIDTH-1:0] sh_cnt_r  [CH];
  logic [CH-1:0]    sh_ovf_r;
  logic             snap_done_r;

  rd_state_t        state_r;
  rd_state_t        state_nxt_s;
  logic             accept_s;
  logic             rd_ack_r;
  logic [WIDTH-1:0] rd_data_r;
  logic             rd_ovf_r;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_ovf_s;

  // Live counter next-state: clr beats snapshot reload, which beats counting.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      ovf_nxt_s[i] = ovf_r[i];
      if (clr) begin
        cnt_nxt_s[i] = CNT_ZERO;
        ovf_nxt_s[i] = 1'b0;
      end else if (snap && (CLR_ON_SNAP != 0)) begin
        cnt_nxt_s[i] = vld[i] ? CNT_ONE : CNT_ZERO;
        ovf_nxt_s[i] = 1'b0;
      end else if (vld[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          cnt_nxt_s[i] = (SAT != 0) ? CNT_MAX : CNT_ZERO;
          ovf_nxt_s[i] = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Live counters, sticky flags, shadows (pre-update values) and snap_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        cnt_r[i]    <= CNT_ZERO;
        sh_cnt_r[i] <= CNT_ZERO;
      end
      ovf_r       <= {CH{1'b0}};
      sh_ovf_r    <= {CH{1'b0}};
      snap_done_r <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
        if (snap) begin
          sh_cnt_r[i] <= cnt_r[i];
        end
      end
      ovf_r <= ovf_nxt_s;
      if (snap) begin
        sh_ovf_r <= ovf_r;
      end
      snap_done_r <= snap;
    end
  end

  // Shadow read mux; indices beyond the bank read as zero.
  always_comb begin
    sel_data_s = CNT_ZERO;
    sel_ovf_s  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (rd_idx == IW'(i)) begin
        sel_data_s = sh_cnt_r[i];
        sel_ovf_s  = sh_ovf_r[i];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Read FSM next state; a request is accepted only from IDLE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rd_req) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (rd_req) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (rd_req) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Read FSM state and response registers; ack is high exactly while in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      rd_ack_r  <= 1'b0;
      rd_data_r <= CNT_ZERO;
      rd_ovf_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      rd_ack_r <= accept_s;
      if (accept_s) begin
        rd_data_r <= sel_data_s;
        rd_ovf_r  <= sel_ovf_s;
      end
    end
  end

  assign snap_done = snap_done_r;
  assign rd_ack    = rd_ack_r;
  assign rd_data   = rd_data_r;
  assign rd_ovf    = rd_ovf_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_cmip_app_cnt_bank.sv
// Scoreboard bench for cmip_app_cnt_bank: three instances (wrap, saturate,
// clear-on-snap) share one clock; reads push expectations, a monitor checks acks.
module tb_cmip_app_cnt_bank;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [2:0]     clr, snap, rd_req, snap_done, rd_ack, rd_ovf;
  logic [3:0]     vld     [3];
  logic [2:0]     rd_idx  [3];
  logic [W-1:0]   rd_data [3];
  logic [3:0]     ovf     [3];

  typedef struct {
    int         dut;
    logic [W-1:0] data;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   ack_cnt [3];

  always @(posedge clk) cyc <= cyc + 1;

  cmip_app_cnt_bank #(.CH(4), .WIDTH(W), .SAT(0), .CLR_ON_SNAP(0), .IW(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .vld(vld[0]), .snap(snap[0]),
    .snap_done(snap_done[0]), .rd_req(rd_req[0]), .rd_idx(rd_idx[0]),
    .rd_ack(rd_ack[0]), .rd_data(rd_data[0]), .rd_ovf(rd_ovf[0]), .ovf(ovf[0]));

  cmip_app_cnt_bank #(.CH(4), .WIDTH(W), .SAT(1), .CLR_ON_SNAP(0), .IW(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .vld(vld[1]), .snap(snap[1]),
    .snap_done(snap_done[1]), .rd_req(rd_req[1]), .rd_idx(rd_idx[1]),
    .rd_ack(rd_ack[1]), .rd_data(rd_data[1]), .rd_ovf(rd_ovf[1]), .ovf(ovf[1]));

  cmip_app_cnt_bank #(.CH(4), .WIDTH(W), .SAT(0), .CLR_ON_SNAP(1), .IW(3)) u_cos (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .vld(vld[2]), .snap(snap[2]),
    .snap_done(snap_done[2]), .rd_req(rd_req[2]), .rd_idx(rd_idx[2]),
    .rd_ack(rd_ack[2]), .rd_data(rd_data[2]), .rd_ovf(rd_ovf[2]), .ovf(ovf[2]));

  task automatic check(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: snap_done must follow the sampled snap by one cycle; each ack pops one expectation.
  task automatic monitor();
    logic [2:0] snap_prev;
    exp_t e;
    snap_prev = 3'b000;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("snap_done_dut%0d", d), int'(snap_done[d]), int'(snap_prev[d]));
        if (rd_ack[d] === 1'b1) begin
          ack_cnt[d]++;
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_ack_dut%0d", d), 1, 0);
          end else begin
            e = exp_q.pop_front();
            tests++;
            if (e.dut != d || rd_data[d] !== e.data || rd_ovf[d] !== e.ovf || cyc != e.cyc + 1) begin
              fails++;
              $display("FAIL rd_resp dut%0d: got data=%0d ovf=%b cyc=%0d expected dut%0d data=%0d ovf=%b cyc=%0d",
                       d, rd_data[d], rd_ovf[d], cyc, e.dut, e.data, e.ovf, e.cyc + 1);
            end
          end
        end
      end
      snap_prev = rst_n ? snap : 3'b000;
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(negedge clk);
    check("ack_timeout_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_read(int d, int idx, int data, int ov, bit with_snap);
    exp_t e;
    e.dut = d; e.data = W'(data); e.ovf = ov[0]; e.cyc = cyc;
    exp_q.push_back(e);
    rd_req[d] = 1'b1;
    rd_idx[d] = 3'(idx);
    if (with_snap) snap[d] = 1'b1;
    step(1);
    rd_req[d] = 1'b0;
    snap[d]   = 1'b0;
    wait_empty();
    step(1);
  endtask

  task automatic chk_zero(int d, string tag);
    check($sformatf("%s_rd_ack_dut%0d", tag, d), int'(rd_ack[d]), 0);
    check($sformatf("%s_rd_data_dut%0d", tag, d), int'(rd_data[d]), 0);
    check($sformatf("%s_rd_ovf_dut%0d", tag, d), int'(rd_ovf[d]), 0);
    check($sformatf("%s_snap_done_dut%0d", tag, d), int'(snap_done[d]), 0);
    check($sformatf("%s_ovf_dut%0d", tag, d), int'(ovf[d]), 0);
  endtask

  initial begin
    int s1 [4];
    int a0;
    s1 = '{10, 0, 10, 0};
    rst_n = 1'b0; clr = 3'b000; snap = 3'b000; rd_req = 3'b000;
    for (int d = 0; d < 3; d++) begin
      vld[d] = 4'b0000; rd_idx[d] = 3'd0; ack_cnt[d] = 0;
    end
    fork
      monitor();
    join_none
    #12;
    for (int d = 0; d < 3; d++) chk_zero(d, "reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(1);
    do_read(0, 1, 0, 0, 1'b0);

    // Two channels counting for 10 cycles, then snapshot and read every index.
    vld[0] = 4'b0101;
    step(10);
    vld[0] = 4'b0000; snap[0] = 1'b1;
    step(1);
    snap[0] = 1'b0;
    for (int i = 0; i < 4; i++) do_read(0, i, s1[i], 0, 1'b0);
    do_read(0, 5, 0, 0, 1'b0);
    check("s1_live_ovf", int'(ovf[0]), 0);

    // Clear with events in the same cycle, then 17 increments: wrap vs saturate.
    clr[1:0] = 2'b11; vld[0] = 4'b1111; vld[1] = 4'b1111;
    step(1);
    clr[1:0] = 2'b00; vld[0] = 4'b0001; vld[1] = 4'b0001;
    step(17);
    vld[0] = 4'b0000; vld[1] = 4'b0000;
    check("wrap_live_ovf", int'(ovf[0]), 1);
    check("sat_live_ovf", int'(ovf[1]), 1);
    snap[1:0] = 2'b11;
    step(1);
    snap[1:0] = 2'b00;
    do_read(0, 0, 1, 1, 1'b0);
    do_read(0, 2, 0, 0, 1'b0);
    do_read(1, 0, 15, 1, 1'b0);
    do_read(1, 1, 0, 0, 1'b0);

    // Snapshot on the acceptance cycle returns the older shadow and stays stable.
    vld[0] = 4'b0001;
    step(3);
    vld[0] = 4'b0000;
    do_read(0, 0, 1, 1, 1'b1);
    step(2);
    check("rd_data_held", int'(rd_data[0]), 1);
    do_read(0, 0, 4, 1, 1'b0);

    // Clear-on-snap: snapshot at count 7 while events keep arriving.
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0; vld[2] = 4'b0010;
    step(7);
    snap[2] = 1'b1;
    step(1);
    snap[2] = 1'b0; vld[2] = 4'b0000;
    check("cos_live_ovf", int'(ovf[2]), 0);
    do_read(2, 1, 7, 0, 1'b0);
    snap[2] = 1'b1;
    step(1);
    snap[2] = 1'b0;
    do_read(2, 1, 1, 0, 1'b0);

    // Snap and clr together at count 5: shadow keeps 5, live goes to 0.
    vld[2] = 4'b0100;
    step(5);
    snap[2] = 1'b1; clr[2] = 1'b1;
    step(1);
    snap[2] = 1'b0; clr[2] = 1'b0; vld[2] = 4'b0000;
    check("snapclr_live_ovf", int'(ovf[2]), 0);
    do_read(2, 2, 5, 0, 1'b0);
    snap[2] = 1'b1;
    step(1);
    snap[2] = 1'b0;
    do_read(2, 2, 0, 0, 1'b0);

    // A request held for 5 cycles yields exactly one ack.
    a0 = ack_cnt[0];
    begin
      exp_t e;
      e.dut = 0; e.data = W'(4); e.ovf = 1'b1; e.cyc = cyc;
      exp_q.push_back(e);
    end
    rd_req[0] = 1'b1; rd_idx[0] = 3'd0;
    step(5);
    rd_req[0] = 1'b0;
    wait_empty();
    step(2);
    check("held_req_one_ack", ack_cnt[0] - a0, 1);

    // Reset while the response is in flight: everything clears, no late ack.
    rd_req[0] = 1'b1; rd_idx[0] = 3'd0;
    step(1);
    rd_req[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    a0 = ack_cnt[0];
    for (int d = 0; d < 3; d++) chk_zero(d, "midread_reset");
    step(2);
    rst_n = 1'b1;
    step(4);
    check("no_ack_after_reset", ack_cnt[0] - a0, 0);
    chk_zero(0, "post_reset");
    do_read(0, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
